// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control sequencer for the 16-bit CPU.
// Fetches an instruction into ir, decodes major (ir[15:12]) and extended
// (ir[7:4]) opcodes and sequences PC, register file, ALU, flag and memory
// strobes. Memory uses a req/ready handshake with an optional timeout.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_rdata         memory read data (instruction or load data)
//   mem_ready         memory completes the current request this cycle
//   cond_true         condition-code unit result for ir[11:8]
//   run               1 = execute, 0 = halt at next FETCH entry
//   ir                instruction register
//   mem_req/mem_we    memory request (held until ready) / write strobe
//   addr_sel          0 = PC addresses memory, 1 = Rsrc addresses memory
//   pc_en/pc_sel      PC load enable / source (PC+1, PC+imm8, Rsrc, pc_load_val)
//   pc_load_val       constant RESET_PC
//   reg_we/wb_sel     register write enable / writeback source (ALU, mem_rdata)
//   imm_sel/alu_op    ALU B operand select / ALU function
//   flags_we          flag register write enable
//   state             current state, for debug
//   illegal/bus_err   sticky unknown-opcode / memory-timeout flags
module cpu_control_fsm #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        cond_true,
    input  logic        run,
    output logic [15:0] ir,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic [15:0] pc_load_val,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        imm_sel,
    output logic [3:0]  alu_op,
    output logic        flags_we,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {K_ALU, K_BR, K_JMP, K_LD, K_ST} kind_t;

    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_LUI = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    state_t        state_q;
    kind_t         kind_q;
    logic          fetch_busy;   // fetch request already issued, must be held
    logic [WW-1:0] wait_cnt;
    logic          wait_hit;

    kind_t         dec_kind;
    logic [3:0]    dec_op;
    logic          dec_imm;
    logic          dec_ok;

    // Opcode code -> {valid, alu_op}; shared by R-type ext and immediate majors.
    function automatic logic [4:0] map_alu(input logic [3:0] c);
        case (c)
            4'b0101: map_alu = {1'b1, 4'd0};
            4'b1001: map_alu = {1'b1, 4'd1};
            4'b0001: map_alu = {1'b1, 4'd2};
            4'b0010: map_alu = {1'b1, 4'd3};
            4'b0011: map_alu = {1'b1, 4'd4};
            4'b1101: map_alu = {1'b1, 4'd5};
            4'b1011: map_alu = {1'b1, 4'd7};
            default: map_alu = 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        logic [4:0] m;
        dec_ok   = 1'b1;
        dec_kind = K_ALU;
        dec_op   = 4'd0;
        dec_imm  = 1'b1;
        m        = '0;
        case (ir[15:12])
            4'b0000: begin
                m       = map_alu(ir[7:4]);
                dec_ok  = m[4];
                dec_op  = m[3:0];
                dec_imm = 1'b0;
            end
            4'b1111: dec_op = OP_LUI;
            4'b0100: begin
                case (ir[7:4])
                    4'b0000: dec_kind = K_LD;
                    4'b0100: dec_kind = K_ST;
                    4'b1100: dec_kind = K_JMP;
                    default: dec_ok   = 1'b0;
                endcase
            end
            4'b1100: dec_kind = K_BR;
            default: begin
                m      = map_alu(ir[15:12]);
                dec_ok = m[4];
                dec_op = m[3:0];
            end
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'd0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        flags_we = 1'b0;
        case (state_q)
            S_RESET: begin
                // Quiet while reset is held; loads RESET_PC on the first cycle after.
                pc_en  = rst_n;
                pc_sel = 2'd3;
            end
            S_FETCH: begin
                // run only gates the first cycle; a started request is held.
                mem_req = fetch_busy | run;
                pc_en   = mem_req & mem_ready;
            end
            S_EXEC: begin
                case (kind_q)
                    K_ALU: begin
                        flags_we = (alu_op != OP_MOV) && (alu_op != OP_LUI);
                        reg_we   = (alu_op != OP_CMP);
                    end
                    K_BR: begin
                        pc_en  = cond_true;
                        pc_sel = 2'd1;
                    end
                    K_JMP: begin
                        pc_en  = cond_true;
                        pc_sel = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (kind_q == K_ST);
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = 1'b1;
            end
            default: ;
        endcase
    end

    // Fires on the MAX_WAIT-th consecutive unanswered request cycle.
    assign wait_hit = (MAX_WAIT != 0) && mem_req && !mem_ready &&
                      (wait_cnt == WW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            kind_q     <= K_ALU;
            ir         <= '0;
            alu_op     <= '0;
            imm_sel    <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
            fetch_busy <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
            else                       wait_cnt <= '0;

            case (state_q)
                S_RESET: state_q <= S_FETCH;
                S_FETCH: begin
                    if (!fetch_busy && !run) begin
                        state_q <= S_HALT;
                    end else if (mem_ready) begin
                        ir         <= mem_rdata;
                        fetch_busy <= 1'b0;
                        state_q    <= S_DECODE;
                    end else if (wait_hit) begin
                        bus_err    <= 1'b1;
                        fetch_busy <= 1'b0;
                        state_q    <= S_HALT;
                    end else begin
                        fetch_busy <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_ok) begin
                        kind_q  <= dec_kind;
                        alu_op  <= dec_op;
                        imm_sel <= dec_imm;
                        state_q <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_EXEC: state_q <= (kind_q == K_LD || kind_q == K_ST) ? S_MEM : S_FETCH;
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= (kind_q == K_ST) ? S_FETCH : S_WB;
                    end else if (wait_hit) begin
                        bus_err <= 1'b1;
                        state_q <= S_HALT;
                    end
                end
                S_WB:   state_q <= S_FETCH;
                S_HALT: if (run && !bus_err) state_q <= S_FETCH;
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign state       = state_q;
    assign pc_load_val = RESET_PC;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed self-checking bench for cpu_control_fsm.
// Each instruction is expanded from the opcode rules into a per-cycle list of
// expected outputs; one compare process checks every cycle at the falling edge.
module tb_cpu_control_fsm;

    localparam int unsigned MAXW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        cond_true;
    logic        run;
    logic [15:0] ir;
    logic        mem_req, mem_we, addr_sel, pc_en;
    logic [1:0]  pc_sel;
    logic [15:0] pc_load_val;
    logic        reg_we, wb_sel, imm_sel;
    logic [3:0]  alu_op;
    logic        flags_we;
    logic [2:0]  state;
    logic        illegal, bus_err;

    cpu_control_fsm #(.RESET_PC(16'h0040), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .cond_true(cond_true), .run(run), .ir(ir), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .pc_en(pc_en), .pc_sel(pc_sel),
        .pc_load_val(pc_load_val), .reg_we(reg_we), .wb_sel(wb_sel),
        .imm_sel(imm_sel), .alu_op(alu_op), .flags_we(flags_we), .state(state),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ready; logic [15:0] rdata; bit cond; bit run;
        logic [2:0] st; bit req, we, asel, pcen; logic [1:0] pcsel;
        bit regwe, wbsel, flwe;
        bit chk_alu; logic [3:0] aluop; bit imm;
    } cyc_t;

    cyc_t        exp;
    bit          exp_on = 0;
    logic [15:0] m_ir = '0;
    bit          m_ill = 0, m_be = 0;
    int          checks = 0, failures = 0, req_cnt = 0;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("state", 16'(state), 16'(exp.st));
            chk("mem_req", 16'(mem_req), 16'(exp.req));
            chk("mem_we", 16'(mem_we), 16'(exp.we));
            chk("addr_sel", 16'(addr_sel), 16'(exp.asel));
            chk("pc_en", 16'(pc_en), 16'(exp.pcen));
            if (exp.pcen || exp.st == 3'd0) chk("pc_sel", 16'(pc_sel), 16'(exp.pcsel));
            chk("reg_we", 16'(reg_we), 16'(exp.regwe));
            chk("wb_sel", 16'(wb_sel), 16'(exp.wbsel));
            chk("flags_we", 16'(flags_we), 16'(exp.flwe));
            chk("ir", ir, m_ir);
            chk("illegal", 16'(illegal), 16'(m_ill));
            chk("bus_err", 16'(bus_err), 16'(m_be));
            chk("pc_load_val", pc_load_val, 16'h0040);
            if (exp.chk_alu) begin
                chk("alu_op", 16'(alu_op), 16'(exp.aluop));
                chk("imm_sel", 16'(imm_sel), 16'(exp.imm));
            end
            if (mem_req && state == 3'd4) req_cnt++;
        end
    end

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t e;
        e = '{ready: 0, rdata: 16'h0, cond: 0, run: 1, st: st, req: 0, we: 0,
              asel: 0, pcen: 0, pcsel: 2'd0, regwe: 0, wbsel: 0, flwe: 0,
              chk_alu: 0, aluop: 4'd0, imm: 0};
        return e;
    endfunction

    task automatic cyc(input cyc_t e);
        mem_ready = e.ready; mem_rdata = e.rdata; cond_true = e.cond; run = e.run;
        exp = e; exp_on = 1;
        @(posedge clk); #1;
    endtask

    // kind: 0 ALU, 1 Bcond, 2 Jcond, 3 LOAD, 4 STOR, 5 illegal.
    // codes[op] is the opcode value naming ALU function op (slot 6 = LUI, major 1111).
    function automatic void classify(input logic [15:0] w, output int kind,
                                     output logic [3:0] op, output bit imm);
        logic [3:0] codes [8] = '{4'd5, 4'd9, 4'd1, 4'd2, 4'd3, 4'd13, 4'd15, 4'd11};
        logic [3:0] maj, ext;
        maj = w[15:12]; ext = w[7:4];
        kind = 5; op = 4'd0; imm = 0;
        if (maj == 4'd12) kind = 1;
        else if (maj == 4'd4) begin
            if (ext == 4'd0) kind = 3;
            else if (ext == 4'd4) kind = 4;
            else if (ext == 4'd12) kind = 2;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (maj == 4'd0 && i != 6 && ext == codes[i]) begin
                    kind = 0; op = 4'(i); imm = 0;
                end else if (maj != 4'd0 && maj == codes[i]) begin
                    kind = 0; op = 4'(i); imm = 1;
                end
            end
        end
    endfunction

    task automatic do_instr(input logic [15:0] w, input bit cond, input int fw,
                            input int mw, input bit run_w);
        int kind; logic [3:0] op; bit imm; cyc_t e;
        classify(w, kind, op, imm);
        for (int i = 0; i < fw; i++) begin
            e = blank(3'd1); e.req = 1; e.cond = cond; e.run = (i == 0) ? 1'b1 : run_w;
            cyc(e);
        end
        e = blank(3'd1); e.req = 1; e.ready = 1; e.rdata = w; e.pcen = 1; e.pcsel = 2'd0;
        e.cond = cond; e.run = (fw == 0) ? 1'b1 : run_w;
        cyc(e);
        m_ir = w;
        e = blank(3'd2); e.cond = cond; e.run = run_w;
        cyc(e);
        if (kind == 5) begin
            m_ill = 1;
            return;
        end
        e = blank(3'd3); e.cond = cond; e.run = run_w;
        if (kind == 0) begin
            e.chk_alu = 1; e.aluop = op; e.imm = imm;
            e.flwe = (op != 4'd5 && op != 4'd6);
            e.regwe = (op != 4'd7);
        end else if (kind == 1 || kind == 2) begin
            e.pcen = cond; e.pcsel = (kind == 1) ? 2'd1 : 2'd2;
        end
        cyc(e);
        if (kind == 3 || kind == 4) begin
            for (int i = 0; i <= mw; i++) begin
                e = blank(3'd4); e.req = 1; e.asel = 1; e.we = (kind == 4);
                e.ready = (i == mw); e.rdata = 16'hBEEF; e.cond = cond; e.run = run_w;
                cyc(e);
            end
            if (kind == 3) begin
                e = blank(3'd5); e.regwe = 1; e.wbsel = 1; e.run = run_w;
                cyc(e);
            end
        end
    endtask

    task automatic hold_reset(input int n);
        cyc_t e;
        rst_n = 0;
        m_ir = '0; m_ill = 0; m_be = 0;
        e = blank(3'd0); e.pcsel = 2'd3; e.ready = 1; e.rdata = 16'hFFFF; e.cond = 1;
        for (int i = 0; i < n; i++) cyc(e);
    endtask

    task automatic release_reset();
        cyc_t e;
        rst_n = 1;
        e = blank(3'd0); e.pcen = 1; e.pcsel = 2'd3;
        cyc(e);
    endtask

    initial begin
        int k; logic [3:0] op; bit imm; cyc_t e;
        rst_n = 1; run = 1; mem_ready = 0; mem_rdata = '0; cond_true = 0;
        #1;
        hold_reset(2);
        release_reset();

        // Model pins: hand-decoded opcodes.
        classify(16'h0152, k, op, imm);
        chk("model_add_kind", 16'(k), 16'd0); chk("model_add_op", 16'(op), 16'd0);
        classify(16'hB305, k, op, imm);
        chk("model_cmpi_op", 16'(op), 16'd7); chk("model_cmpi_imm", 16'(imm), 16'd1);
        classify(16'h7000, k, op, imm);
        chk("model_ill_kind", 16'(k), 16'd5);
        classify(16'hC0FE, k, op, imm);
        chk("model_bcond_kind", 16'(k), 16'd1);

        do_instr(16'h0152, 0, 0, 0, 1);   // ADD R1,R2
        do_instr(16'hB305, 1, 0, 0, 1);   // CMPI
        do_instr(16'h0152, 0, 2, 0, 0);   // fetch stall, run dropped in flight
        do_instr(16'h01D2, 0, 0, 0, 1);   // MOV
        do_instr(16'hF1AB, 0, 0, 0, 1);   // LUI
        do_instr(16'h1234, 1, 1, 0, 1);   // ANDI
        req_cnt = 0;
        do_instr(16'h4102, 0, 0, 3, 1);   // LOAD, ready after 3 waits
        chk("load_req_cycles", 16'(req_cnt), 16'd4);
        do_instr(16'h4142, 1, 0, 1, 1);   // STOR
        do_instr(16'hC0FE, 1, 0, 0, 1);   // Bcond taken
        do_instr(16'hC0FE, 0, 0, 0, 1);   // Bcond not taken
        do_instr(16'h40C3, 1, 0, 0, 1);   // Jcond taken
        do_instr(16'h40C3, 0, 0, 0, 1);   // Jcond not taken
        do_instr(16'h7000, 1, 0, 0, 1);   // illegal major
        do_instr(16'h0072, 0, 0, 0, 1);   // illegal R-type ext
        do_instr(16'h9011, 0, 0, 0, 1);   // SUBI after illegal

        // run=0 at FETCH entry: no request, HALT, resume on run=1.
        e = blank(3'd1); e.run = 0; e.ready = 1; e.rdata = 16'hFFFF; cyc(e);
        e = blank(3'd6); e.run = 0; cyc(e);
        e = blank(3'd6); e.run = 1; cyc(e);
        do_instr(16'h3456, 0, 0, 0, 1);   // XORI

        // Fetch timeout: MAXW unanswered cycles, then sticky bus_err in HALT.
        for (int i = 0; i < int'(MAXW); i++) begin
            e = blank(3'd1); e.req = 1; cyc(e);
        end
        m_be = 1;
        for (int i = 0; i < 4; i++) begin
            e = blank(3'd6); e.run = i[0]; cyc(e);
        end
        hold_reset(1);
        release_reset();
        do_instr(16'h0152, 0, 0, 0, 1);

        // Reset in the middle of an outstanding fetch.
        for (int i = 0; i < 2; i++) begin
            e = blank(3'd1); e.req = 1; cyc(e);
        end
        hold_reset(1);
        release_reset();
        do_instr(16'h2077, 0, 0, 0, 1);   // ORI
        exp_on = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
